// File: rtl/sram_arb2.sv
// Two-client round-robin arbiter in front of the SRAM core issue port; a tag FIFO steers read data back to its issuer.
// Optional define SRAM_ARB_LOCK_EN adds m0_lock/m1_lock so one client can hold the port across several issues.
module sram_arb2 #(
  parameter int TAG_DEPTH = 4,
  parameter int AW        = 18,
  parameter int DW        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_req,
  output logic            m0_ready,
  input  logic            m0_rd,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW/8-1:0] m0_be,
  input  logic [DW-1:0]   m0_wr_data,
  output logic            m0_rd_data_vld,
  output logic [DW-1:0]   m0_rd_data,
  input  logic            m1_req,
  output logic            m1_ready,
  input  logic            m1_rd,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW/8-1:0] m1_be,
  input  logic [DW-1:0]   m1_wr_data,
  output logic            m1_rd_data_vld,
  output logic [DW-1:0]   m1_rd_data,
`ifdef SRAM_ARB_LOCK_EN
  input  logic            m0_lock,
  input  logic            m1_lock,
`endif
  output logic            sram_req,
  input  logic            sram_ready,
  output logic            sram_rd,
  output logic [AW-1:0]   sram_addr,
  output logic [DW/8-1:0] sram_be,
  output logic [DW-1:0]   sram_wr_data,
  input  logic            sram_rd_data_vld,
  input  logic [DW-1:0]   sram_rd_data,
  output logic            tag_err
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic                 prio_q, prio_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;
  logic                 tag_err_q, tag_err_d;
  logic                 lock_valid_q, lock_valid_d;
  logic                 lock_id_q, lock_id_d;

  logic tag_full, fifo_nonempty, head;
  logic allow0, allow1, elig0, elig1;
  logic gnt_vld, gnt_id, issue, push, pop, gnt_lock;

  // Eligibility, grant selection and request mux toward the core
  always_comb begin
    tag_full      = (count_q == FULL_CNT);
    fifo_nonempty = (count_q != {CW{1'b0}});
    head          = tag_q[rd_ptr_q];
    allow0        = 1'b1;
    allow1        = 1'b1;
    gnt_lock      = 1'b0;
`ifdef SRAM_ARB_LOCK_EN
    if (lock_valid_q) begin
      allow0 = !lock_id_q;
      allow1 = lock_id_q;
    end else begin
      allow0 = 1'b1;
      allow1 = 1'b1;
    end
`endif
    elig0 = allow0 && m0_req && !(m0_rd && tag_full);
    elig1 = allow1 && m1_req && !(m1_rd && tag_full);
    if (elig0 && elig1) begin
      gnt_id = prio_q;
    end else if (elig1) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
    gnt_vld = elig0 || elig1;
`ifdef SRAM_ARB_LOCK_EN
    gnt_lock = gnt_id ? m1_lock : m0_lock;
`endif
    sram_req     = gnt_vld;
    sram_rd      = gnt_id ? m1_rd      : m0_rd;
    sram_addr    = gnt_id ? m1_addr    : m0_addr;
    sram_be      = gnt_id ? m1_be      : m0_be;
    sram_wr_data = gnt_id ? m1_wr_data : m0_wr_data;
    issue        = gnt_vld && sram_ready;
    m0_ready     = gnt_vld && !gnt_id && sram_ready;
    m1_ready     = gnt_vld &&  gnt_id && sram_ready;
    push         = issue && sram_rd;
    pop          = sram_rd_data_vld && fifo_nonempty;
    m0_rd_data_vld = pop && !head;
    m1_rd_data_vld = pop &&  head;
    m0_rd_data     = sram_rd_data;
    m1_rd_data     = sram_rd_data;
    tag_err        = tag_err_q;
  end

  // Next-state for priority, lock, tag FIFO and the sticky error
  always_comb begin
    prio_d       = prio_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    tag_d        = tag_q;
    tag_err_d    = tag_err_q || (sram_rd_data_vld && !fifo_nonempty);
    // A held lock freezes round-robin so the other client resumes from its old turn
    if (issue && !lock_valid_q) begin
      prio_d = ~gnt_id;
    end else begin
      prio_d = prio_q;
    end
    if (issue && gnt_lock) begin
      lock_valid_d = 1'b1;
      lock_id_d    = gnt_id;
    end else if (issue && lock_valid_q && (gnt_id == lock_id_q)) begin
      lock_valid_d = 1'b0;
    end else begin
      lock_valid_d = lock_valid_q;
    end
    if (push) begin
      tag_d[wr_ptr_q] = gnt_id;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q       <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      tag_q        <= {TAG_DEPTH{1'b0}};
      tag_err_q    <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tag_q        <= tag_d;
      tag_err_q    <= tag_err_d;
    end
  end

endmodule

// File: doc/sram_arb2.md
Name: sram_arb2

Overview:
- Two-client arbiter that sits directly upstream of the SRAM core issue interface (sram_req/sram_ready/sram_rd/sram_addr/sram_be/sram_wr_data) and downstream of two independent masters (m0, m1).
- Arbitrates round-robin, forwards the winning request, and records the issuing client of each read in a tag FIFO.
- Routes returning sram_rd_data_vld/sram_rd_data back to the client that issued the read. Read data returns in issue order.

Parameters:
- TAG_DEPTH, 4, number of outstanding reads tracked; power of 2, minimum 2.
- AW, 18, address width.
- DW, 16, data width; byte enable width is DW/8.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- m0_req  in  1  client 0 request valid
- m0_ready  out  1  client 0 request accepted this cycle
- m0_rd  in  1  1 = read, 0 = write
- m0_addr  in  AW  address
- m0_be  in  DW/8  byte enables
- m0_wr_data  in  DW  write data
- m0_rd_data_vld  out  1  read data valid for client 0
- m0_rd_data  out  DW  read data
- m1_*  same set as m0_*, for client 1
- m0_lock, m1_lock  in  1  only present with SRAM_ARB_LOCK_EN
- sram_req  out  1  to SRAM core
- sram_ready  in  1  from SRAM core
- sram_rd  out  1  to SRAM core
- sram_addr  out  AW  to SRAM core
- sram_be  out  DW/8  to SRAM core
- sram_wr_data  out  DW  to SRAM core
- sram_rd_data_vld  in  1  from SRAM core
- sram_rd_data  in  DW  from SRAM core
- tag_err  out  1  sticky: read data arrived with tag FIFO empty

Behaviour:
- Eligibility: mN_elig = mN_req && !(mN_rd && tag_full), where tag_full means count == TAG_DEPTH. Writes are never blocked by tag_full.
- Grant (combinational, every cycle):
  - If both clients are eligible, grant goes to the client selected by prio (reg, 0 = m0).
  - If one is eligible, grant goes to that client.
  - If none is eligible, sram_req = 0.
- sram_req equals the granted client's eligibility. sram_rd/addr/be/wr_data are muxed from the granted client, and from m0 when no client is granted.
- mN_ready = granted(N) && sram_ready. An issue occurs when sram_req && sram_ready. No combinational path from sram_ready to sram_req.
- prio update: on each issue, prio <= ~granted_id. With no issue, prio holds.
- Tag FIFO: depth TAG_DEPTH, 1-bit entries, wr_ptr/rd_ptr wrap mod TAG_DEPTH, count 0..TAG_DEPTH.
  - Push the granted id on each issue with sram_rd = 1.
  - Pop on sram_rd_data_vld when count > 0.
  - Push and pop in the same cycle leave count unchanged.
  - A read is blocked when count == TAG_DEPTH, even if a pop happens in the same cycle.
- Return path (combinational from inputs and FIFO head):
  - mN_rd_data_vld = sram_rd_data_vld && count > 0 && head == N.
  - m0_rd_data = m1_rd_data = sram_rd_data.
  - Read latency adds 0 cycles.
- sram_rd_data_vld with count == 0: no pop, no client vld, tag_err <= 1. tag_err clears only on reset.
- Reset values: prio = 0, pointers = 0, count = 0, tag_err = 0. All outputs are then 0 unless driven through from inputs.
- Reset mid-operation clears the FIFO, and in-flight reads are lost. The SRAM core shares the same reset, so no stale data returns.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- Defined:
  - m0_lock/m1_lock ports exist.
  - An issue from client N with mN_lock = 1 sets lock_valid = 1 and lock_id = N.
  - While lock_valid, only lock_id can be granted and prio does not update.
  - An issue with mN_lock = 0 from lock_id clears lock_valid.
  - Reset clears lock_valid.
- Undefined: the ports and logic are absent, and arbitration is pure round-robin.

Test Plan:
- Only m0 issues writes, addr 0x00010..0x00013, sram_ready = 1 → 4 issues on consecutive cycles; m0_ready high each cycle; m1_ready = 0.
- Both clients request writes continuously, sram_ready = 1 → grants alternate m0, m1, m0, m1…; first grant is m0 after reset.
- m0 read 0x00100, then m1 read 0x00200; core returns 0xAAAA, then 0xBBBB → m0_rd_data_vld with 0xAAAA, then m1_rd_data_vld with 0xBBBB; never both valid.
- TAG_DEPTH = 4: issue 4 reads with no return; 5th read request stalls (mN_ready = 0) while a pending write from the other client still issues; one return cycle → next cycle the read issues.
- sram_rd_data_vld pulse with FIFO empty → no client vld; tag_err = 1 and holds; assert reset → tag_err = 0, prio = 0.
- SRAM_ARB_LOCK_EN: m1 issues with m1_lock = 1 twice, then m1_lock = 0, while m0 requests continuously → 3 consecutive m1 grants, then m0 granted.
